// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: optional dirty-victim writeback, line refill, tag commit.
// Define CACHE_CRITICAL_WORD_FIRST_EN to start the refill at the missing word.
`ifndef CACHE_T
`define CACHE_T 26
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_refill_ctrl #(
    parameter int TAG_WIDTH    = `CACHE_T,
    parameter int OFFSET_WIDTH = `CACHE_B
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req,
    input  logic [31:0]             addr,
    input  logic                    hit,
    input  logic                    dirty,
    input  logic [TAG_WIDTH-1:0]    replace_tag,
    output logic [OFFSET_WIDTH-3:0] victim_idx,
    input  logic [31:0]             victim_data,
    output logic                    mem_req,
    output logic                    mem_wen,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_ready,
    output logic                    fill_wen,
    output logic [OFFSET_WIDTH-3:0] fill_idx,
    output logic [31:0]             fill_data,
    output logic                    tag_wen,
    output logic                    stall
);

    localparam int IW         = OFFSET_WIDTH - 2;
    localparam int SW         = 32 - TAG_WIDTH - OFFSET_WIDTH;
    localparam int LINE_WORDS = 2 ** IW;
    localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        COMMIT
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [TAG_WIDTH-1:0] ltag_q, rtag_q;
    logic [SW-1:0]        lset_q;
    logic                 latch;
    logic [IW-1:0]        start_new, start_lat;
    logic                 unused_bits;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    logic [IW-1:0] lword_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            lword_q <= '0;
        else if (latch)
            lword_q <= addr[OFFSET_WIDTH-1:2];
    end

    assign start_new   = addr[OFFSET_WIDTH-1:2];
    assign start_lat   = lword_q;
    assign unused_bits = ^addr[1:0];
`else
    assign start_new   = '0;
    assign start_lat   = '0;
    assign unused_bits = ^addr[OFFSET_WIDTH-1:0];
`endif

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ltag_q  <= '0;
            lset_q  <= '0;
            rtag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                ltag_q <= addr[31 -: TAG_WIDTH];
                lset_q <= addr[31-TAG_WIDTH:OFFSET_WIDTH];
                rtag_q <= replace_tag;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        victim_idx = '0;
        mem_req    = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_wen   = 1'b0;
        fill_idx   = '0;
        fill_data  = '0;
        tag_wen    = 1'b0;
        stall      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    // held low while resetn is asserted so every output reads 0
                    stall = resetn;
                    latch = 1'b1;
                    if (dirty) begin
                        state_d = WRITEBACK;
                        cnt_d   = '0;
                    end else begin
                        state_d = REFILL;
                        cnt_d   = start_new;
                    end
                end
            end
            WRITEBACK: begin
                stall      = 1'b1;
                mem_req    = 1'b1;
                mem_wen    = 1'b1;
                victim_idx = cnt_q;
                mem_wdata  = victim_data;
                mem_addr   = {rtag_q, lset_q, cnt_q, 2'b00};
                if (mem_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = REFILL;
                        cnt_d   = start_lat;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {ltag_q, lset_q, cnt_q, 2'b00};
                if (mem_ready) begin
                    fill_wen  = 1'b1;
                    fill_idx  = cnt_q;
                    fill_data = mem_rdata;
                    cnt_d     = cnt_inc;
                    // the line is complete once the counter wraps to its start
                    if (cnt_inc == start_lat)
                        state_d = COMMIT;
                end
            end
            COMMIT: begin
                stall   = 1'b1;
                tag_wen = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl (TAG_WIDTH=26, OFFSET_WIDTH=4).
// Expected memory and fill traffic is queued at each miss and retired by a monitor.
module tb_cache_refill_ctrl;

    localparam int TW = 26;
    localparam int OW = 4;
    localparam int IW = 2;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct {
        logic [IW-1:0] idx;
        logic [31:0]   data;
    } fexp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req, hit, dirty;
    logic [31:0]   addr;
    logic [TW-1:0] replace_tag;
    logic [IW-1:0] victim_idx;
    logic [31:0]   victim_data;
    logic          mem_req, mem_wen;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;
    logic          mem_ready;
    logic          fill_wen;
    logic [IW-1:0] fill_idx;
    logic [31:0]   fill_data;
    logic          tag_wen, stall;

    int    n_chk = 0;
    int    n_fail = 0;
    int    lat = 0;
    int    wcnt = 0;
    int    rd_cyc = 0;
    int    fills_seen = 0;
    logic  idle_noise = 1'b0;
    mexp_t mq[$];
    fexp_t fq[$];
    mexp_t mon_e;
    fexp_t mon_f;

    cache_refill_ctrl #(
        .TAG_WIDTH   (TW),
        .OFFSET_WIDTH(OW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .addr       (addr),
        .hit        (hit),
        .dirty      (dirty),
        .replace_tag(replace_tag),
        .victim_idx (victim_idx),
        .victim_data(victim_data),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .fill_wen   (fill_wen),
        .fill_idx   (fill_idx),
        .fill_data  (fill_data),
        .tag_wen    (tag_wen),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    assign victim_data = 32'hDEAD_0000 | 32'(victim_idx);
    assign mem_rdata   = mem_addr ^ 32'hC0DE_0000;
    assign mem_ready   = idle_noise | (mem_req && (wcnt == lat));

    always @(posedge clk) begin
        if (!mem_req || mem_ready)
            wcnt <= 0;
        else
            wcnt <= wcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] start_word(input logic [31:0] a);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        return a[OW-1:2];
`else
        return a[OW-1:2] & 2'b00;
`endif
    endfunction

    task automatic push_miss(input logic [31:0] a, input logic [TW-1:0] rt,
                             input logic d);
        mexp_t         me;
        fexp_t         fe;
        logic [IW-1:0] w;
        if (d) begin
            for (int i = 0; i < 4; i++) begin
                me.wen   = 1'b1;
                me.addr  = {rt, a[5:4], 2'(i), 2'b00};
                me.wdata = 32'hDEAD_0000 | i;
                mq.push_back(me);
            end
        end
        for (int i = 0; i < 4; i++) begin
            w        = start_word(a) + 2'(i);
            me.wen   = 1'b0;
            me.addr  = {a[31:4], w, 2'b00};
            me.wdata = '0;
            mq.push_back(me);
            fe.idx   = w;
            fe.data  = me.addr ^ 32'hC0DE_0000;
            fq.push_back(fe);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_stall"}, 32'(stall), 0);
        check({nm, "_mem_req"}, 32'(mem_req), 0);
        check({nm, "_mem_wen"}, 32'(mem_wen), 0);
        check({nm, "_mem_addr"}, mem_addr, 0);
        check({nm, "_mem_wdata"}, mem_wdata, 0);
        check({nm, "_fill_wen"}, 32'(fill_wen), 0);
        check({nm, "_fill_idx"}, 32'(fill_idx), 0);
        check({nm, "_fill_data"}, fill_data, 0);
        check({nm, "_tag_wen"}, 32'(tag_wen), 0);
        check({nm, "_victim_idx"}, 32'(victim_idx), 0);
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [TW-1:0] rt,
                           input logic d, input int l, input string nm);
        int cyc;
        int expc;
        lat  = l;
        expc = 2 + 4 * (l + 1) * (d ? 2 : 1);
        @(posedge clk);
        #1;
        req         = 1'b1;
        hit         = 1'b0;
        dirty       = d;
        addr        = a;
        replace_tag = rt;
        rd_cyc      = 0;
        push_miss(a, rt, d);
        @(negedge clk);
        check({nm, "_miss_stall"}, 32'(stall), 1);
        @(posedge clk);
        #1;
        req         = 1'b0;
        dirty       = ~d;
        addr        = ~a;
        replace_tag = ~rt;
        cyc         = 2;
        @(negedge clk);
        while (!tag_wen && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_commit_cycle"}, cyc, expc);
        check({nm, "_commit_stall"}, 32'(stall), 1);
        check({nm, "_refill_cycles"}, rd_cyc, 4 * (l + 1));
        @(posedge clk);
        #1;
        req  = 1'b1;
        hit  = 1'b1;
        addr = a;
        @(negedge clk);
        check({nm, "_after_stall"}, 32'(stall), 0);
        check({nm, "_after_mem_req"}, 32'(mem_req), 0);
        check({nm, "_after_tag_wen"}, 32'(tag_wen), 0);
        @(posedge clk);
        #1;
        req = 1'b0;
        check({nm, "_mq_left"}, mq.size(), 0);
        check({nm, "_fq_left"}, fq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (mem_req) begin
                if (!mem_wen)
                    rd_cyc++;
                check("mem_expected", 32'(mq.size() > 0), 1);
                if (mq.size() > 0) begin
                    mon_e = mq[0];
                    check("mem_addr", mem_addr, mon_e.addr);
                    check("mem_wen", 32'(mem_wen), 32'(mon_e.wen));
                    if (mon_e.wen)
                        check("mem_wdata", mem_wdata, mon_e.wdata);
                    if (mem_ready)
                        mon_e = mq.pop_front();
                end
            end
            if (fill_wen) begin
                fills_seen++;
                check("fill_handshake", {29'b0, mem_req, mem_ready, mem_wen}, 32'b110);
                check("fill_expected", 32'(fq.size() > 0), 1);
                if (fq.size() > 0) begin
                    mon_f = fq.pop_front();
                    check("fill_idx", 32'(fill_idx), 32'(mon_f.idx));
                    check("fill_data", fill_data, mon_f.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        resetn      = 1'b0;
        req         = 1'b1;
        hit         = 1'b0;
        dirty       = 1'b1;
        addr        = 32'h0000_1238;
        replace_tag = '1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        req    = 1'b0;

        @(posedge clk);
        #1;
        req        = 1'b1;
        hit        = 1'b1;
        dirty      = 1'b1;
        addr       = 32'h0000_1238;
        idle_noise = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("hit_stall", 32'(stall), 0);
            check("hit_mem_req", 32'(mem_req), 0);
            check("hit_fill_wen", 32'(fill_wen), 0);
            check("hit_tag_wen", 32'(tag_wen), 0);
        end
        @(posedge clk);
        #1;
        idle_noise = 1'b0;
        req        = 1'b0;
        @(negedge clk);
        check("hit_after_mem_req", 32'(mem_req), 0);

        do_miss(32'h0000_1238, 26'h0, 1'b0, 0, "clean");
        do_miss(32'h0000_1238, 26'h0000ABC, 1'b1, 0, "dirty");
        do_miss(32'h0000_1238, 26'h0, 1'b0, 3, "slow");
        do_miss(32'h0000_5674, 26'h1234567, 1'b1, 2, "dslow");

        lat = 0;
        @(posedge clk);
        #1;
        req         = 1'b1;
        hit         = 1'b0;
        dirty       = 1'b0;
        addr        = 32'h0000_1238;
        replace_tag = '0;
        base        = fills_seen;
        push_miss(addr, replace_tag, 1'b0);
        @(posedge clk);
        #1;
        n = 0;
        while (fills_seen < base + 2 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_mid_fills", fills_seen - base, 2);
        resetn = 1'b0;
        #1;
        check_zero("rst_mid");
        mq.delete();
        fq.delete();
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("post_rst_mem_req", 32'(mem_req), 0);
            check("post_rst_fill_wen", 32'(fill_wen), 0);
            check("post_rst_tag_wen", 32'(tag_wen), 0);
            check("post_rst_stall", 32'(stall), 0);
        end

        do_miss(32'h8000_0074, 26'h2AAAAAA, 1'b1, 1, "recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
